// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data-memory port: registers the winning command,
// routes the response back to its owner, and forces an error response if memory goes silent.
module dmem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_req,
    input  logic        i_m0_we,
    input  logic [3:0]  i_m0_be,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_err,
    input  logic        i_m1_req,
    input  logic        i_m1_we,
    input  logic [3:0]  i_m1_be,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_err,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,
    output logic        o_spurious_rvalid
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0] NO_DATA = 32'hbabecafe;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]    state_r;
    logic          owner_r;
    logic          last_owner_r;
    logic [CW-1:0] cnt_r;
    logic          spurious_r;

    logic          winner_s;
    logic          gnt_s;
    logic          resp_valid_s;
    logic          resp_err_s;
    logic [31:0]   resp_rdata_s;

    // On a tie the port that did not win last time goes first.
    assign winner_s     = (i_m0_req && i_m1_req) ? ~last_owner_r : i_m1_req;
    assign gnt_s        = (state_r == ST_REQ) && data_gnt_i;
    assign resp_valid_s = (state_r == ST_WAIT) && (data_rvalid_i || (cnt_r == CNT_LAST));
    assign resp_err_s   = data_rvalid_i ? data_err_i : 1'b1;
    assign resp_rdata_s = data_rvalid_i ? data_rdata_i : NO_DATA;

    assign o_m0_gnt    = gnt_s && !owner_r;
    assign o_m1_gnt    = gnt_s && owner_r;
    assign o_m0_rvalid = resp_valid_s && !owner_r;
    assign o_m1_rvalid = resp_valid_s && owner_r;
    assign o_m0_err    = o_m0_rvalid && resp_err_s;
    assign o_m1_err    = o_m1_rvalid && resp_err_s;
    assign o_m0_rdata  = o_m0_rvalid ? resp_rdata_s : NO_DATA;
    assign o_m1_rdata  = o_m1_rvalid ? resp_rdata_s : NO_DATA;

    assign o_spurious_rvalid = spurious_r;

    // Transaction FSM, command registers, timeout counter and sticky spurious flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            last_owner_r <= 1'b1;
            cnt_r        <= '0;
            spurious_r   <= 1'b0;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'h0;
            data_addr_o  <= 32'h0;
            data_wdata_o <= 32'h0;
        end else begin
            if (data_rvalid_i && (state_r != ST_WAIT)) begin
                spurious_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (i_m0_req || i_m1_req) begin
                        owner_r      <= winner_s;
                        data_req_o   <= 1'b1;
                        data_we_o    <= winner_s ? i_m1_we    : i_m0_we;
                        data_be_o    <= winner_s ? i_m1_be    : i_m0_be;
                        data_addr_o  <= winner_s ? i_m1_addr  : i_m0_addr;
                        data_wdata_o <= winner_s ? i_m1_wdata : i_m0_wdata;
                        state_r      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (data_gnt_i) begin
                        last_owner_r <= owner_r;
                        cnt_r        <= '0;
                        data_req_o   <= 1'b0;
                        data_we_o    <= 1'b0;
                        data_be_o    <= 4'h0;
                        data_addr_o  <= 32'h0;
                        data_wdata_o <= 32'h0;
                        state_r      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The counter stops at its last value; that cycle emits the forced response.
                    if (data_rvalid_i || (cnt_r == CNT_LAST)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single core data-memory port (req/gnt/rvalid protocol) between the core LSU (port 0) and a secondary master such as debug or DMA (port 1). It sits between the requesters and the memory-side signals `data_req_o` … `data_err_i`. It registers the winning command and holds it stable until granted. It routes the response back to the owner and returns an error response if memory never answers. One transaction is outstanding at a time.

## Interface
- `TIMEOUT`, default 255: WAIT_R cycles without `data_rvalid_i` before a forced error response. Legal range ≥2.
- `i_clk` input 1: clock. All state updates on the rising edge.
- `i_rst` input 1: reset, synchronous, active-high.
- `i_mN_req` input 1 (N=0,1): request. Held by master until `o_mN_gnt`.
- `i_mN_we` input 1: write enable.
- `i_mN_be` input 4: byte enables.
- `i_mN_addr` input 32: address.
- `i_mN_wdata` input 32: write data.
- `o_mN_gnt` output 1: command accepted by memory.
- `o_mN_rvalid` output 1: response valid to master N.
- `o_mN_rdata` output 32: read data.
- `o_mN_err` output 1: response error.
- `data_req_o`, `data_we_o` output 1; `data_be_o` output 4; `data_addr_o`, `data_wdata_o` output 32: registered command to memory.
- `data_gnt_i`, `data_rvalid_i`, `data_err_i` input 1; `data_rdata_i` input 32: memory responses.
- `o_spurious_rvalid` output 1: sticky flag, set by `data_rvalid_i` outside WAIT_R.

## Operation
- FSM states: IDLE, REQ, WAIT_R.
- IDLE:
  - If any `i_mN_req` is high, pick the winner.
    - Only one requesting: that one wins.
    - Both requesting: the port other than `last_owner` wins.
  - Latch `owner` and the winner's we/be/addr/wdata into the command registers. Go to REQ.
- REQ:
  - `data_req_o`=1 with the latched command. Command is held constant until `data_gnt_i`.
  - On `data_gnt_i`: `o_{owner}_gnt`=1 combinationally in that cycle. Set `last_owner`←owner, clear the timeout counter, go to WAIT_R. Command registers clear (`data_req_o`←0).
- WAIT_R:
  - `o_{owner}_rvalid` = `data_rvalid_i`.
  - `o_{owner}_rdata` = `data_rdata_i`.
  - `o_{owner}_err` = `data_err_i`.
  - On rvalid: go to IDLE.
  - Else the counter increments. When the counter equals TIMEOUT-1 with no rvalid: force `o_{owner}_rvalid`=1, `o_{owner}_err`=1, `o_{owner}_rdata`=32'hbabecafe, and go to IDLE.
- The non-owner's gnt and rvalid are always 0. Every `o_mN_rdata` is 32'hbabecafe when its rvalid is 0.
- `data_rvalid_i` in IDLE or REQ is ignored for routing and sets `o_spurious_rvalid`, which is cleared only by reset.
- Known limitation: a response arriving after a timeout, during the next WAIT_R, is taken as that transaction's response. The bench must not rely on this.
- Counter width is $clog2(TIMEOUT); the counter saturates (never wraps) before the forced response.
- Reset values:
  - State IDLE, `last_owner`=1 (port 0 wins the first tie).
  - All gnt/rvalid/err outputs 0.
  - `data_req_o`/`data_we_o` 0; `data_be_o` 4'h0; `data_addr_o`/`data_wdata_o` 0.
  - `o_spurious_rvalid` 0.
- Reset mid-transaction: the pending command is dropped and no response is returned to the owner. A late rvalid after reset sets `o_spurious_rvalid`.

## Timing
- Request first seen in IDLE at cycle N → `data_req_o`=1 from N+1.
- `data_gnt_i` at N+1 → `o_mN_gnt` at N+1; WAIT_R from N+2.
- Earliest response at N+2, forwarded in the same cycle (zero added latency). IDLE at N+3.
- Next command reaches memory at N+4 at earliest. Best-case throughput is one access per 3 cycles.
- A gnt stall extends REQ indefinitely, with no timeout in REQ.
- A master dropping `i_mN_req` before its gnt does not cancel a latched command: the gnt is still issued and the response still routed.
- Forced error response occurs in the TIMEOUT-th cycle of WAIT_R.

## Test plan
- Single read, port 0:
  - Stimulus: addr 32'h100, gnt at the first `data_req_o` cycle, rvalid 2 cycles later with rdata 32'h12345678.
  - Required: `data_req_o` at N+1; `o_m0_gnt` at N+1; `o_m0_rvalid`/`o_m0_rdata`=32'h12345678 at N+3; port 1 outputs silent.
- Both masters request continuously for 4 transactions:
  - Required: owner sequence 0,1,0,1; each command's addr/we/be/wdata matches its master.
- Gnt stall:
  - Stimulus: `data_gnt_i` held low 5 cycles.
  - Required: `data_req_o` high and command stable for 6 cycles; single gnt pulse.
- Timeout:
  - Stimulus: TIMEOUT=4, no rvalid after gnt.
  - Required: `o_m1_rvalid`=1, `o_m1_err`=1, `o_m1_rdata`=32'hbabecafe in the 4th WAIT_R cycle; IDLE next cycle.
- Spurious and reset:
  - Stimulus 1: rvalid pulse in IDLE. Required: `o_spurious_rvalid`=1 and no master rvalid.
  - Stimulus 2: `i_rst` asserted in WAIT_R. Required: all outputs at reset values the next cycle and the flag cleared.
- Write:
  - Stimulus: port 1 we=1, be=4'b0011, wdata 32'hdeadbeef, response with `data_err_i`=1.
  - Required: `data_we_o`=1, `data_be_o`=4'b0011, `data_wdata_o`=32'hdeadbeef; `o_m1_err`=1 with rvalid.
